// File: rtl/router_pkt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_ctrl_pkg
// Description : Shared types and constants for the router packet controller.
//               Holds the 8-state FSM encoding, the Moore output bundle, and a
//               helper that decodes a state into its control outputs.
// Revision    : 1.0  initial release
// ============================================================================
package router_pkt_ctrl_pkg;

  localparam int ADDR_W = 2;   // header address field width
  localparam int LEN_W  = 6;   // header payload-length field width
  localparam int NPORT  = 3;   // output ports (fixed)

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam logic [LEN_W-1:0]  LEN_MAX      = 6'd63;

  typedef enum logic [2:0] {
    ST_DECODE_ADDRESS     = 3'd0,
    ST_LOAD_FIRST_DATA    = 3'd1,
    ST_LOAD_DATA          = 3'd2,
    ST_LOAD_PARITY        = 3'd3,
    ST_FIFO_FULL          = 3'd4,
    ST_LOAD_AFTER_FULL    = 3'd5,
    ST_WAIT_TILL_EMPTY    = 3'd6,
    ST_CHECK_PARITY_ERROR = 3'd7
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic write_enb_reg;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic busy;
  } ctrl_out_t;

  // Moore decode of a state into the controller outputs.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_DECODE_ADDRESS: o.detect_add = 1'b1;
      ST_LOAD_FIRST_DATA: begin
        o.write_enb_reg = 1'b1;
        o.lfd_state     = 1'b1;
        o.busy          = 1'b1;
      end
      ST_LOAD_DATA: begin
        o.write_enb_reg = 1'b1;
        o.ld_state      = 1'b1;
      end
      ST_LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      ST_FIFO_FULL: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      ST_LOAD_AFTER_FULL: begin
        o.write_enb_reg = 1'b1;
        o.laf_state     = 1'b1;
        o.busy          = 1'b1;
      end
      ST_WAIT_TILL_EMPTY: o.busy = 1'b1;
      ST_CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_ctrl_len_chk.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_ctrl_len_chk
// Description : Payload length checker. Counts payload bytes written for the
//               current packet (saturating at LEN_MAX) and compares the count
//               with the header length when the parity byte is loaded.
// Ports       : clk, rst (sync, active-low)
//               i_state        current controller state
//               i_pkt_valid    packet byte valid
//               i_fifo_full    selected FIFO full
//               i_parity_done  parity byte captured
//               i_hdr_len      header length field
//               o_len_err      registered length mismatch flag
// Revision    : 1.0  initial release
// ============================================================================
module router_pkt_ctrl_len_chk
  import router_pkt_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  state_t           i_state,
  input  logic             i_pkt_valid,
  input  logic             i_fifo_full,
  input  logic             i_parity_done,
  input  logic [LEN_W-1:0] i_hdr_len,
  output logic             o_len_err
);

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_hdr_len;
  logic             r_len_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_hdr_len <= '0;
      r_len_err <= 1'b0;
    end else begin
      // A new header clears the previous packet's verdict.
      if (i_state == ST_DECODE_ADDRESS && i_pkt_valid) begin
        r_hdr_len <= i_hdr_len;
        r_len_err <= 1'b0;
      end
      case (i_state)
        ST_LOAD_FIRST_DATA: r_cnt <= '0;
        ST_LOAD_DATA: begin
          if (i_pkt_valid && !i_fifo_full && r_cnt != LEN_MAX)
            r_cnt <= r_cnt + LEN_W'(1);
        end
        // The byte held during the full stall is written here.
        ST_LOAD_AFTER_FULL: begin
          if (!i_parity_done && r_cnt != LEN_MAX)
            r_cnt <= r_cnt + LEN_W'(1);
        end
        ST_LOAD_PARITY: r_len_err <= (r_cnt != r_hdr_len);
        default: ;
      endcase
    end
  end

  assign o_len_err = r_len_err;

endmodule
`default_nettype wire

// File: rtl/router_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_ctrl
// Description : Packet-level controller FSM for the 1x3 router input side.
//               Decodes the header address, waits for the target FIFO to
//               drain, sequences header/payload/parity loading, stalls on
//               FIFO full and issues the parity check.
// Config      : ROUTER_PKT_LEN_CHECK_EN enables the payload length checker;
//               when undefined o_len_err is tied low and i_hdr_len is ignored.
// Ports       : clk, rst (sync, active-low)
//               i_pkt_valid, i_din, i_hdr_len      source side
//               i_fifo_full, i_fifo_empty, i_soft_rst  sync block
//               i_parity_done, i_low_pkt_valid      register block
//               o_detect_add, o_write_enb_reg, o_lfd_state, o_ld_state,
//               o_laf_state, o_full_state, o_rst_int_reg, o_busy, o_len_err
// Revision    : 1.0  initial release
// ============================================================================
module router_pkt_ctrl
  import router_pkt_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pkt_valid,
  input  logic [ADDR_W-1:0] i_din,
  input  logic [LEN_W-1:0]  i_hdr_len,
  input  logic              i_fifo_full,
  input  logic [NPORT-1:0]  i_fifo_empty,
  input  logic [NPORT-1:0]  i_soft_rst,
  input  logic              i_parity_done,
  input  logic              i_low_pkt_valid,
  output logic              o_detect_add,
  output logic              o_write_enb_reg,
  output logic              o_lfd_state,
  output logic              o_ld_state,
  output logic              o_laf_state,
  output logic              o_full_state,
  output logic              o_rst_int_reg,
  output logic              o_busy,
  output logic              o_len_err
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  ctrl_out_t         r_out;

  // Pad the per-port vectors to 4 entries so the 2-bit address (including
  // the invalid value 3) always indexes in range; entry 3 reads as 0.
  logic [3:0] w_empty_vec;
  logic [3:0] w_soft_vec;
  logic       w_soft_hit;

  assign w_empty_vec = {1'b0, i_fifo_empty};
  assign w_soft_vec  = {1'b0, i_soft_rst};
  assign w_soft_hit  = (r_addr != ADDR_INVALID) && w_soft_vec[r_addr];

  always_comb begin
    w_next = r_state;
    if (w_soft_hit) begin
      w_next = ST_DECODE_ADDRESS;
    end else begin
      case (r_state)
        ST_DECODE_ADDRESS: begin
          if (i_pkt_valid && i_din != ADDR_INVALID)
            w_next = w_empty_vec[i_din] ? ST_LOAD_FIRST_DATA : ST_WAIT_TILL_EMPTY;
        end
        ST_WAIT_TILL_EMPTY: begin
          if (w_empty_vec[r_addr]) w_next = ST_LOAD_FIRST_DATA;
        end
        ST_LOAD_FIRST_DATA: w_next = ST_LOAD_DATA;
        ST_LOAD_DATA: begin
          if (i_fifo_full)       w_next = ST_FIFO_FULL;
          else if (!i_pkt_valid) w_next = ST_LOAD_PARITY;
        end
        ST_FIFO_FULL: begin
          if (!i_fifo_full) w_next = ST_LOAD_AFTER_FULL;
        end
        ST_LOAD_AFTER_FULL: begin
          if (i_parity_done)        w_next = ST_DECODE_ADDRESS;
          else if (i_low_pkt_valid) w_next = ST_LOAD_PARITY;
          else                      w_next = ST_LOAD_DATA;
        end
        ST_LOAD_PARITY: w_next = ST_CHECK_PARITY_ERROR;
        ST_CHECK_PARITY_ERROR: begin
          w_next = i_fifo_full ? ST_FIFO_FULL : ST_DECODE_ADDRESS;
        end
        default: w_next = ST_DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they always match
  // the state register without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_DECODE_ADDRESS;
      r_addr  <= ADDR_INVALID;
      r_out   <= decode_outputs(ST_DECODE_ADDRESS);
    end else begin
      r_state <= w_next;
      r_out   <= decode_outputs(w_next);
      if (r_state == ST_DECODE_ADDRESS && i_pkt_valid)
        r_addr <= i_din;
    end
  end

  assign o_detect_add    = r_out.detect_add;
  assign o_write_enb_reg = r_out.write_enb_reg;
  assign o_lfd_state     = r_out.lfd_state;
  assign o_ld_state      = r_out.ld_state;
  assign o_laf_state     = r_out.laf_state;
  assign o_full_state    = r_out.full_state;
  assign o_rst_int_reg   = r_out.rst_int_reg;
  assign o_busy          = r_out.busy;

`ifdef ROUTER_PKT_LEN_CHECK_EN
  router_pkt_ctrl_len_chk u_len_chk (
    .clk           (clk),
    .rst           (rst),
    .i_state       (r_state),
    .i_pkt_valid   (i_pkt_valid),
    .i_fifo_full   (i_fifo_full),
    .i_parity_done (i_parity_done),
    .i_hdr_len     (i_hdr_len),
    .o_len_err     (o_len_err)
  );
`else
  logic w_unused_hdr_len;
  assign w_unused_hdr_len = ^i_hdr_len;
  assign o_len_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_ctrl
// Description : Self-checking bench for router_pkt_ctrl. A behavioural model
//               of the packet controller predicts all outputs every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_router_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] din;
  logic [5:0] hdr_len;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_rst;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, write_enb_reg, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy, len_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_pkt_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_pkt_valid     (pkt_valid),
    .i_din           (din),
    .i_hdr_len       (hdr_len),
    .i_fifo_full     (fifo_full),
    .i_fifo_empty    (fifo_empty),
    .i_soft_rst      (soft_rst),
    .i_parity_done   (parity_done),
    .i_low_pkt_valid (low_pkt_valid),
    .o_detect_add    (detect_add),
    .o_write_enb_reg (write_enb_reg),
    .o_lfd_state     (lfd_state),
    .o_ld_state      (ld_state),
    .o_laf_state     (laf_state),
    .o_full_state    (full_state),
    .o_rst_int_reg   (rst_int_reg),
    .o_busy          (busy),
    .o_len_err       (len_err)
  );

  // {detect, wr_enb, lfd, ld, laf, full, rst_int, busy, len_err}
  logic [8:0] dut_vec;
  assign dut_vec = {detect_add, write_enb_reg, lfd_state, ld_state, laf_state,
                    full_state, rst_int_reg, busy, len_err};

`ifdef ROUTER_PKT_LEN_CHECK_EN
  localparam bit LEN_ON = 1'b1;
`else
  localparam bit LEN_ON = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  localparam int M_DEC = 10, M_WAIT = 11, M_LFD = 12, M_LD = 13,
                 M_FULL = 14, M_LAF = 15, M_LP = 16, M_CPE = 17;

  int         m_st   = M_DEC;
  logic [1:0] m_addr = 2'b11;
  int         m_hlen = 0;
  int         m_cnt  = 0;
  logic       m_lerr = 1'b0;

  function automatic logic [8:0] exp_vec();
    logic [8:0] v;
    v = '0;
    case (m_st)
      M_DEC:  v[8] = 1'b1;
      M_LFD:  begin v[7] = 1'b1; v[6] = 1'b1; end
      M_LD:   begin v[7] = 1'b1; v[5] = 1'b1; end
      M_LAF:  begin v[7] = 1'b1; v[4] = 1'b1; end
      M_LP:   v[7] = 1'b1;
      M_FULL: v[3] = 1'b1;
      M_CPE:  v[2] = 1'b1;
      default: ;
    endcase
    v[1] = !(m_st == M_DEC || m_st == M_LD);
    v[0] = LEN_ON ? m_lerr : 1'b0;
    return v;
  endfunction

  // Advance one clock: predict from the inputs in force, then take the edge.
  task automatic tick();
    int         n_st, n_hlen, n_cnt;
    logic [1:0] n_addr;
    logic       n_lerr;
    n_st = m_st; n_addr = m_addr; n_hlen = m_hlen; n_cnt = m_cnt; n_lerr = m_lerr;
    if (!rst) begin
      n_st = M_DEC; n_addr = 2'b11; n_hlen = 0; n_cnt = 0; n_lerr = 1'b0;
    end else begin
      if (m_st == M_DEC && pkt_valid) begin
        n_addr = din; n_hlen = int'(hdr_len); n_lerr = 1'b0;
      end
      if (m_st == M_LFD) n_cnt = 0;
      if ((m_st == M_LD && pkt_valid && !fifo_full) || (m_st == M_LAF && !parity_done))
        n_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
      if (m_st == M_LP) n_lerr = (m_cnt != m_hlen);
      if (m_addr != 2'b11 && soft_rst[m_addr]) n_st = M_DEC;
      else begin
        case (m_st)
          M_DEC:  if (pkt_valid && din != 2'b11) n_st = fifo_empty[din] ? M_LFD : M_WAIT;
          M_WAIT: if (fifo_empty[m_addr]) n_st = M_LFD;
          M_LFD:  n_st = M_LD;
          M_LD:   if (fifo_full) n_st = M_FULL; else if (!pkt_valid) n_st = M_LP;
          M_FULL: if (!fifo_full) n_st = M_LAF;
          M_LAF:  n_st = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
          M_LP:   n_st = M_CPE;
          M_CPE:  n_st = fifo_full ? M_FULL : M_DEC;
          default: n_st = M_DEC;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_st = n_st; m_addr = n_addr; m_hlen = n_hlen; m_cnt = n_cnt; m_lerr = n_lerr;
  endtask

  task automatic set_idle();
    pkt_valid = 1'b0; din = 2'b00; hdr_len = 6'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_rst = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    pkt_valid = 1'b1; din = 2'b01; fifo_full = 1'b1; fifo_empty = 3'b000;
    soft_rst = 3'b010; parity_done = 1'b1; low_pkt_valid = 1'b1; hdr_len = 6'd9;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dut_vec !== 9'b1_0000_0000) begin
        failures++;
        $display("FAIL reset_const cyc=%0d got=%b exp=%b", i, dut_vec, 9'b1_0000_0000);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    set_idle();
    rst = 1'b1;
  endtask

  task automatic test_basic_packet();
    int wr_cnt = 0;
    set_idle();
    din = 2'b01; hdr_len = 6'd4;
    for (int i = 0; i < 9; i++) begin
      pkt_valid = (i < 6);
      tick();
      if (write_enb_reg) wr_cnt++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (wr_cnt !== 7) begin
      failures++;
      $display("FAIL basic_wr_cycles got=%0d exp=%0d", wr_cnt, 7);
    end
    checks++;
    if (detect_add !== 1'b1 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_end got det=%b lerr=%b exp det=1 lerr=0", detect_add, len_err);
    end
  endtask

  task automatic test_wait_empty();
    int wait_cnt = 0;
    set_idle();
    din = 2'b10; hdr_len = 6'd1;
    for (int i = 0; i < 9; i++) begin
      fifo_empty = (i < 4) ? 3'b011 : 3'b111;
      pkt_valid  = (i < 6);
      tick();
      if (busy && !write_enb_reg && !full_state && !rst_int_reg) wait_cnt++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL wait cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (wait_cnt !== 4) begin
      failures++;
      $display("FAIL wait_cycles got=%0d exp=%0d", wait_cnt, 4);
    end
  endtask

  task automatic test_fifo_full();
    int full_cnt = 0;
    int laf_cnt  = 0;
    set_idle();
    din = 2'b00; hdr_len = 6'd2;
    for (int i = 0; i < 10; i++) begin
      pkt_valid     = (i < 6);
      fifo_full     = (i >= 3 && i <= 5);
      low_pkt_valid = (i == 7);
      tick();
      if (full_state) full_cnt++;
      if (laf_state)  laf_cnt++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL full cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (full_cnt !== 3 || laf_cnt !== 1) begin
      failures++;
      $display("FAIL full_counts got full=%0d laf=%0d exp full=3 laf=1", full_cnt, laf_cnt);
    end
  endtask

  task automatic test_soft_reset();
    set_idle();
    din = 2'b01;
    for (int i = 0; i < 5; i++) begin
      pkt_valid = 1'b1;
      soft_rst  = (i == 2) ? 3'b101 : (i == 3) ? 3'b001 : (i == 4) ? 3'b010 : 3'b000;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL soft cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (ld_state !== 1'b1) begin
          failures++;
          $display("FAIL soft_other_port got ld=%b exp ld=1", ld_state);
        end
      end
    end
    checks++;
    if (detect_add !== 1'b1) begin
      failures++;
      $display("FAIL soft_own_port got det=%b exp det=1", detect_add);
    end
    set_idle();
  endtask

  task automatic test_len_check(input int npay, input int hlen, input logic err_exp);
    set_idle();
    din = 2'b00; hdr_len = 6'(hlen);
    // header, LFD, npay valid payload cycles in LOAD_DATA, then parity path
    for (int i = 0; i < npay + 5; i++) begin
      pkt_valid = (i < npay + 2);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL len%0d cyc=%0d got=%b exp=%b", npay, i, dut_vec, exp_vec());
      end
      if (i == npay + 3) begin
        checks++;
        if (len_err !== (LEN_ON & err_exp)) begin
          failures++;
          $display("FAIL len_err_cpe n=%0d got=%b exp=%b", npay, len_err, LEN_ON & err_exp);
        end
      end
    end
    // invalid-address header keeps DECODE_ADDRESS but clears the flag
    pkt_valid = 1'b1; din = 2'b11;
    tick();
    checks++;
    if (len_err !== 1'b0 || detect_add !== 1'b1) begin
      failures++;
      $display("FAIL len_clear got lerr=%b det=%b exp lerr=0 det=1", len_err, detect_add);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) != 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      din           = 2'($urandom_range(0, 3));
      hdr_len       = 6'($urandom_range(0, 7));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = 3'($urandom);
      soft_rst      = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    rst = 1'b1;
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_len_check(5, 4, 1'b1);
    test_len_check(4, 4, 1'b0);
    test_len_check(70, 63, 1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
